// File: rtl/tile_n_planner_pkg.sv
// Shared types and default sizing for the tile-count planner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tile_n_planner_pkg;

    localparam int DEF_GLB_MAX_BYTES = 65536;
    localparam int DEF_BYTES_I       = 1;
    localparam int DEF_BYTES_W       = 1;
    localparam int DEF_BYTES_P       = 4;

    typedef enum logic [1:0] {
        LT_POINTWISE = 2'd0,
        LT_DEPTHWISE = 2'd1,
        LT_STANDARD  = 2'd2,
        LT_LINEAR    = 2'd3
    } layer_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_DIV  = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/tile_n_planner_seq_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: i_start edge loads, DATA_W edges iterate, o_done pulses after the last one.
// Backpressure: none; i_start restarts the division unconditionally.
module seq_udiv #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done;

    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W-1:0] w_sub;
    logic              w_ge;

    // Remainder stays below the divisor, so the shifted value needs one extra bit
    // and the difference always fits back into DATA_W bits.
    assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_sub    = w_rem_sh[DATA_W-1:0] - r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_quo <= i_dividend;
                r_rem <= '0;
                r_div <= i_divisor;
                r_cnt <= CNT_W'(DATA_W);
            end else if (r_cnt != '0) begin
                r_quo  <= {r_quo[DATA_W-2:0], w_ge};
                r_rem  <= w_ge ? w_sub : w_rem_sh[DATA_W-1:0];
                r_cnt  <= r_cnt - 1'b1;
                r_done <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/tile_n_planner.sv
// Plans how many tiles fit in global SRAM: floor(free bytes / bytes per tile), clamped and aligned.
// Latency: done pulses DATA_W+3 edges after the start-accepting edge, fault cases included.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module tile_n_planner
    import tile_n_planner_pkg::*;
#(
    parameter int GLB_BYTES = DEF_GLB_MAX_BYTES,
    parameter int BYTES_I   = DEF_BYTES_I,
    parameter int BYTES_W   = DEF_BYTES_W,
    parameter int BYTES_P   = DEF_BYTES_P,
    parameter int DATA_W    = 32,
    parameter int PW_ALIGN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        layer_type,
    input  logic [1:0]        kH,
    input  logic [1:0]        kW,
    input  logic [7:0]        tile_D,
    input  logic [7:0]        tile_K,
    input  logic [7:0]        tile_D_f,
    input  logic [7:0]        tile_K_f,
    input  logic [7:0]        M1,
    input  logic [7:0]        M2,
    input  logic [7:0]        M3,
    input  logic [DATA_W-1:0] n_limit,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] tile_n,
    output logic              err
);

    // Wide enough that byte products of 8-bit operands never wrap, even for small DATA_W.
    localparam int CW = (DATA_W + 2 > 48) ? DATA_W + 2 : 48;
    localparam logic signed [CW-1:0] MAXV = {{(CW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
    localparam logic [DATA_W-1:0] PW_MASK = ~DATA_W'(PW_ALIGN - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    layer_t            r_layer;
    logic [1:0]        r_kh, r_kw;
    logic [7:0]        r_td, r_tk, r_tdf, r_tkf, r_m1, r_m2, r_m3;
    logic [DATA_W-1:0] r_n_limit;
    logic              r_fault;
    logic [DATA_W-1:0] r_tile_n;
    logic              r_err;
    logic              r_done;

    logic [CW-1:0]        w_filt, w_bias, w_mterm, w_den;
    logic signed [CW-1:0] w_num;
    logic                 w_fault;
    logic [DATA_W-1:0]    w_num_u, w_den_u;
    logic                 w_div_start, w_div_done;
    logic [DATA_W-1:0]    w_quo;
    logic [DATA_W-1:0]    w_q_raw, w_q_lim, w_q_final;

    assign w_filt  = CW'(r_kh) * CW'(r_kw) * CW'(r_tdf) * CW'(r_tkf) * CW'(BYTES_W);
    assign w_bias  = CW'(r_tk) * CW'(BYTES_P);
    assign w_mterm = CW'(r_m2) * CW'(r_m3) * CW'(r_tk) * CW'(BYTES_P);
    assign w_den   = CW'(r_m1) * CW'(r_td) * CW'(BYTES_I) + CW'(r_m3) * CW'(r_tk) * CW'(BYTES_P);
    assign w_num   = $signed(CW'(GLB_BYTES)) - $signed(w_filt) - $signed(w_bias) + $signed(w_mterm);
    assign w_fault = (w_num < 0) || (w_den == '0);

    // Operands beyond the divider range saturate; only reachable with a narrow DATA_W.
    assign w_num_u = (w_num > MAXV) ? '1 : w_num[DATA_W-1:0];
    assign w_den_u = (w_den > CW'(MAXV)) ? '1 : w_den[DATA_W-1:0];

    assign w_div_start = (r_state == ST_PREP);

    seq_udiv #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_num_u),
        .i_divisor  (w_den_u),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    assign w_q_raw   = r_fault ? '0 : w_quo;
    assign w_q_lim   = ((r_n_limit != '0) && (w_q_raw > r_n_limit)) ? r_n_limit : w_q_raw;
    assign w_q_final = (r_layer == LT_POINTWISE) ? (w_q_lim & PW_MASK) : w_q_lim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = ST_DIV;
            ST_DIV:  if (w_div_done) w_state_nxt = ST_POST;
            ST_POST: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer   <= LT_POINTWISE;
            r_kh      <= '0;
            r_kw      <= '0;
            r_td      <= '0;
            r_tk      <= '0;
            r_tdf     <= '0;
            r_tkf     <= '0;
            r_m1      <= '0;
            r_m2      <= '0;
            r_m3      <= '0;
            r_n_limit <= '0;
            r_fault   <= 1'b0;
            r_tile_n  <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE && start) begin
                r_layer   <= layer_t'(layer_type);
                r_kh      <= kH;
                r_kw      <= kW;
                r_td      <= tile_D;
                r_tk      <= tile_K;
                r_tdf     <= tile_D_f;
                r_tkf     <= tile_K_f;
                r_m1      <= M1;
                r_m2      <= M2;
                r_m3      <= M3;
                r_n_limit <= n_limit;
            end
            if (r_state == ST_PREP) begin
                r_fault <= w_fault;
            end
            // Results land on the edge entering DONE so done and the data appear together.
            if (r_state == ST_POST) begin
                r_tile_n <= w_q_final;
                r_err    <= r_fault || (w_q_final == '0);
                r_done   <= 1'b1;
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign tile_n = r_tile_n;
    assign err    = r_err;

endmodule

// File: tb/tb_tile_n_planner.sv
// Self-checking bench for tile_n_planner: directed table, randomized model checks, corner sequences.
module tb_tile_n_planner;

    localparam int GLB = 65536;
    localparam int BI  = 1;
    localparam int BW  = 1;
    localparam int BP  = 4;
    localparam int DW_ = 32;
    localparam int LAT = DW_ + 3;

    typedef struct {
        logic [1:0]  lt;
        logic [1:0]  kh, kw;
        logic [7:0]  td, tk, tdf, tkf, m1, m2, m3;
        logic [31:0] nl;
        logic [31:0] exp_t;
        logic        exp_e;
    } vec_t;

    logic        clk, rst_n, start;
    logic [1:0]  layer_type, kH, kW;
    logic [7:0]  tile_D, tile_K, tile_D_f, tile_K_f, M1, M2, M3;
    logic [31:0] n_limit;
    logic        busy, done, err;
    logic [31:0] tile_n;

    int n_checks = 0;
    int n_err    = 0;

    tile_n_planner #(
        .GLB_BYTES (GLB), .BYTES_I (BI), .BYTES_W (BW), .BYTES_P (BP),
        .DATA_W (DW_), .PW_ALIGN (4)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .layer_type (layer_type),
        .kH (kH), .kW (kW), .tile_D (tile_D), .tile_K (tile_K),
        .tile_D_f (tile_D_f), .tile_K_f (tile_K_f), .M1 (M1), .M2 (M2), .M3 (M3),
        .n_limit (n_limit), .busy (busy), .done (done), .tile_n (tile_n), .err (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, got, got, exp);
        end
    endtask

    function automatic vec_t mk(input int lt, kh, kw, td, tk, tdf, tkf, m1, m2, m3,
                                input int nl, input int et, input int ee);
        vec_t v;
        v.lt = 2'(lt); v.kh = 2'(kh); v.kw = 2'(kw);
        v.td = 8'(td); v.tk = 8'(tk); v.tdf = 8'(tdf); v.tkf = 8'(tkf);
        v.m1 = 8'(m1); v.m2 = 8'(m2); v.m3 = 8'(m3);
        v.nl = 32'(nl); v.exp_t = 32'(et); v.exp_e = 1'(ee);
        return v;
    endfunction

    // Reference: plain integer arithmetic straight from the planning formulas.
    function automatic void model(inout vec_t v);
        longint filt, bias, num, den, q;
        filt = longint'(v.kh) * v.kw * v.tdf * v.tkf * BW;
        bias = longint'(v.tk) * BP;
        num  = GLB - filt - bias + longint'(v.m2) * v.m3 * v.tk * BP;
        den  = longint'(v.m1) * v.td * BI + longint'(v.m3) * v.tk * BP;
        q    = (num < 0 || den == 0) ? 0 : num / den;
        if (v.nl != 0 && q > longint'(v.nl)) q = longint'(v.nl);
        if (v.lt == 2'd0) q = q - (q % 4);
        v.exp_t = 32'(q);
        v.exp_e = (num < 0 || den == 0 || q == 0);
    endfunction

    task automatic apply(input vec_t v);
        layer_type = v.lt; kH = v.kh; kW = v.kw;
        tile_D = v.td; tile_K = v.tk; tile_D_f = v.tdf; tile_K_f = v.tkf;
        M1 = v.m1; M2 = v.m2; M3 = v.m3; n_limit = v.nl;
    endtask

    task automatic scramble();
        layer_type = 2'($urandom); kH = 2'($urandom); kW = 2'($urandom);
        tile_D = 8'($urandom); tile_K = 8'($urandom); tile_D_f = 8'($urandom);
        tile_K_f = 8'($urandom); M1 = 8'($urandom); M2 = 8'($urandom); M3 = 8'($urandom);
        n_limit = $urandom;
    endtask

    // One request; operands are scrambled after acceptance to prove they were captured.
    task automatic run_req(input vec_t v, output int lat, output logic [31:0] t,
                           output logic e, output int width);
        @(negedge clk);
        apply(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        lat = -1; t = 'x; e = 1'bx; width = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            scramble();
            if (done) begin
                lat = c; t = tile_n; e = err;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            width = done ? 2 : 1;
        end
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        int lat, width;
        logic [31:0] t;
        logic e;
        run_req(v, lat, t, e, width);
        check({tag, ".latency"}, 64'(lat), 64'(LAT));
        check({tag, ".tile_n"}, {32'd0, t}, {32'd0, v.exp_t});
        check({tag, ".err"}, {63'd0, e}, {63'd0, v.exp_e});
        check({tag, ".done_width"}, 64'(width), 64'd1);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v, v2;
        int done_cnt, first_lat;
        logic [31:0] t1;
        logic e1;

        rst_n = 1'b0; start = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #23;
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.done", {63'd0, done}, 64'd0);
        check("reset.tile_n", {32'd0, tile_n}, 64'd0);
        check("reset.err", {63'd0, err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // lt kh kw td tk tdf tkf m1 m2 m3 n_limit -> tile_n err
        tbl[0] = mk(0, 1, 1, 32, 32, 32, 32, 1, 0, 1, 0,   400, 0);
        tbl[1] = mk(1, 1, 1, 32, 32, 32, 32, 1, 0, 1, 0,   402, 0);
        tbl[2] = mk(0, 1, 1, 32, 32, 32, 32, 1, 0, 1, 99,  96,  0);
        tbl[3] = mk(2, 1, 1, 32, 32, 32, 32, 1, 0, 1, 0,   402, 0);
        tbl[4] = mk(3, 1, 1, 32, 32, 32, 32, 1, 0, 1, 300, 300, 0);
        tbl[5] = mk(0, 3, 3, 32, 32, 255, 255, 1, 0, 1, 0, 0,   1);
        tbl[6] = mk(0, 1, 1, 0, 0, 32, 32, 1, 0, 1, 0,     0,   1);
        tbl[7] = mk(0, 1, 1, 32, 32, 32, 32, 1, 0, 1, 2,   0,   1);
        tbl[8] = mk(0, 1, 1, 32, 32, 32, 32, 1, 2, 1, 0,   404, 0);
        for (int i = 0; i < 9; i++) begin
            run_and_check($sformatf("dir%0d", i), tbl[i]);
        end

        for (int i = 0; i < 24; i++) begin
            v = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 64)), int'($urandom_range(0, 64)),
                   int'($urandom_range(0, 48)), int'($urandom_range(0, 48)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 600)), 0, 0);
            model(v);
            run_and_check($sformatf("rnd%0d", i), v);
        end

        // Restart attempts mid-DIV and during the done cycle are both ignored.
        v  = tbl[0];
        v2 = mk(1, 1, 1, 32, 32, 32, 32, 1, 0, 1, 99, 0, 0);
        @(negedge clk);
        apply(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0; first_lat = -1; t1 = '0; e1 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 6) begin
                apply(v2);
                start = 1'b1;
            end else if (c == 8) begin
                start = 1'b0;
            end
            if (first_lat > 0 && c == first_lat + 1) begin
                apply(v2);
                start = 1'b1;
            end else if (first_lat > 0 && c == first_lat + 2) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (first_lat < 0) begin
                    first_lat = c; t1 = tile_n; e1 = err;
                end
            end
        end
        start = 1'b0;
        check("restart.done_count", 64'(done_cnt), 64'd1);
        check("restart.latency", 64'(first_lat), 64'(LAT));
        check("restart.tile_n", {32'd0, t1}, 64'd400);
        check("restart.err", {63'd0, e1}, 64'd0);
        check("restart.busy_after", {63'd0, busy}, 64'd0);

        // Reset in the middle of the division aborts it without a done pulse.
        @(negedge clk);
        apply(tbl[1]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.busy", {63'd0, busy}, 64'd0);
        check("abort.done", {63'd0, done}, 64'd0);
        check("abort.tile_n", {32'd0, tile_n}, 64'd0);
        check("abort.err", {63'd0, err}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort.no_done", 64'(done_cnt), 64'd0);
        check("abort.idle", {63'd0, busy}, 64'd0);
        run_and_check("after_abort", tbl[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
